seq_detect_scheduler: RTL and testbench
=======================================

// Module: seq_detect_scheduler
// PURPOSE
//  Shares one serial 11011 Moore sequence detector (fsm_11011_moore) between two
//  requesters. Each requester submits a FRAME_W-bit parallel frame.
//  The block arbitrates round-robin, resets the detector, and shifts the frame in MSB-first.
//  It counts detector hits and reports per-frame completion.
//  Sits between frame producers and the detector instance; drives its clear/inp_1, reads its out.
// PARAMETERS
//  FRAME_W  16  bits per frame shifted into detector (>=5)
//  CNT_W    4   width of match_count; saturates at 2**CNT_W-1
// PORTS
//  clk_pulse    in   1        single clock, all logic on posedge
//  clear        in   1        reset, synchronous, active-high
//  req_0        in   1        requester 0 frame pending; hold with frame_0 until grant_0
//  frame_0      in   FRAME_W  requester 0 frame, sampled in grant_0 cycle
//  req_1        in   1        requester 1 frame pending
//  frame_1      in   FRAME_W  requester 1 frame
//  grant_0      out  1        1-cycle pulse: frame_0 accepted
//  grant_1      out  1        1-cycle pulse: frame_1 accepted
//  det_clear    out  1        to detector clear; = clear | (state==GRANT)
//  det_inp      out  1        to detector inp_1; serial frame bit
//  det_out      in   1        from detector out (Moore, 1 cycle after final bit sampled)
//  busy         out  1        high in GRANT/SHIFT/DRAIN/DONE
//  done         out  1        1-cycle pulse: frame finished, match_count valid
//  done_id      out  1        requester of finished frame; holds until next done
//  match_count  out  CNT_W    detections in last frame; holds until next GRANT
// BEHAVIOUR
//  Reset (clear=1): state IDLE; grant_*, det_inp, busy, done, done_id, match_count = 0.
//   Round-robin pointer favours requester 0. det_clear=1 while clear asserted.
//  Reset mid-frame aborts immediately. No done is issued. Partial count is discarded.
//  FSM (Moore; outputs decoded from registered state):
//   IDLE  : any req -> GRANT; else stay.
//   GRANT : 1 cycle. grant_<w>=1 and det_clear=1. Latch frame_<w> into shift reg.
//           Latch w into done_id_next. match_count<=0, bit_cnt<=0 -> SHIFT.
//   SHIFT : FRAME_W cycles. Cycle k: det_inp = frame[FRAME_W-1-k]. After k=FRAME_W-1 -> DRAIN.
//   DRAIN : 1 cycle, det_inp=0. Captures det_out for the final bit -> DONE.
//   DONE  : done=1, done_id=w. Any req -> GRANT (back-to-back). Else -> IDLE.
//  Counting: match_count += 1 on each cycle with det_out=1.
//   Window is SHIFT cycles k=1..FRAME_W-1 plus DRAIN (det_out lags det_inp by 1 cycle).
//   det_out ignored in IDLE/GRANT/DONE. Saturating add, no wrap.
//  Arbitration: evaluated in IDLE/DONE on current req_*.
//   Both requesting: grant the one not granted last; pointer updates on grant.
//   Single req: granted regardless of pointer. req dropped before grant = withdrawn, no grant.
//  req_* during busy is held pending. Frames are never interleaved or pre-empted.
//  Latency: req seen in IDLE at cycle t -> grant at t+1 -> done at t+FRAME_W+3.
//   Frame period back-to-back = FRAME_W+3 cycles.
//  det_inp=0 outside SHIFT. grant_0 & grant_1 never both 1.
// STRUCTURE
//  seq_defs.vh (shared include): state encodings IDLE/GRANT/SHIFT/DRAIN/DONE.
//   Also SEQ_PATTERN=5'b11011 and SEQ_LEN=5 for benches/reference models.
//  Sub-module seq_rr_arbiter: 2-way round-robin, inputs req_0/req_1/advance,
//   outputs winner id + valid.
//  Top holds FSM, shift register, bit counter ($clog2(FRAME_W)+1 bits), saturating counter.
//  Detector stays external; bench instantiates fsm_11011_moore, wired det_* <-> clear/inp_1/out.
// TESTING (bench: clk_pulse period 10ns, drive inputs on negedge)
//  1 Reset: clear=1 3 cycles, req_0=1 -> no grant.
//    All outputs 0 and det_clear=1. Release -> grant_0 next cycle.
//  2 Single frame: req_0, frame_0=16'hD800 -> grant_0 pulse. det_inp serial 1,1,0,1,1,0...
//    done at grant+18 cycles, done_id=0, match_count=1.
//  3 Two matches: frame_1=16'hD9B0 via req_1 -> done_id=1, match_count=2.
//    frame 16'h0000 -> match_count=0.
//  4 Contention: req_0=req_1=1 held continuously, frames D800/D9B0.
//    Grants alternate 0,1,0,1 back-to-back, period 19 cycles. Counts 1,2,1,2.
//  5 Abort: clear asserted at SHIFT k=6.
//    Next cycle IDLE, busy=0, no done, match_count=0. Next frame still counts correctly.
//  6 Saturation: CNT_W=1, frame_0=16'hD9B0 -> match_count=1 (saturated, not wrapped).
//    Withdrawn req (1 cycle, dropped in busy) -> no grant.

Source files
------------

// File: rtl/seq_detect_scheduler_pkg.sv
// Shared definitions for the 11011 detector scheduler.
//   state_e     : scheduler FSM encodings (IDLE/GRANT/SHIFT/DRAIN/DONE)
//   SEQ_PATTERN : the serial pattern the shared detector recognises
//   SEQ_LEN     : pattern length in bits
package seq_detect_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [4:0] SEQ_PATTERN = 5'b11011;
  localparam int         SEQ_LEN     = 5;

endpackage

// File: rtl/fsm_11011_moore.sv
// Serial 11011 Moore detector with overlap.
//   clk_pulse : clock (posedge)
//   clear     : synchronous active-high reset to the empty-prefix state
//   inp_1     : serial input bit, sampled each posedge
//   out       : 1 for one cycle after the final 1 of 11011 is sampled
module fsm_11011_moore (
  input  logic clk_pulse,
  input  logic clear,
  input  logic inp_1,
  output logic out
);

  // State name = length of the pattern prefix matched so far.
  typedef enum logic [2:0] {
    S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4, S5 = 3'd5
  } det_state_e;

  det_state_e state_q, state_d;

  always_ff @(posedge clk_pulse) begin
    if (clear) state_q <= S0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S0:      state_d = inp_1 ? S1 : S0;
      S1:      state_d = inp_1 ? S2 : S0;
      S2:      state_d = inp_1 ? S2 : S3;
      S3:      state_d = inp_1 ? S4 : S0;
      S4:      state_d = inp_1 ? S5 : S0;
      // After a hit, the trailing "11" is reused as the next prefix.
      S5:      state_d = inp_1 ? S2 : S3;
      default: state_d = S0;
    endcase
  end

  assign out = (state_q == S5);

endmodule

// File: rtl/seq_rr_arbiter.sv
// Two-way round-robin arbiter.
//   clk_pulse/clear : clock and synchronous active-high reset
//   req_0/req_1     : current requests
//   advance         : commit the current winner as "last granted"
//   winner          : id of the requester that would be granted now
//   valid           : at least one request present
// After reset requester 0 has priority (last granted is taken as 1).
module seq_rr_arbiter (
  input  logic clk_pulse,
  input  logic clear,
  input  logic req_0,
  input  logic req_1,
  input  logic advance,
  output logic winner,
  output logic valid
);

  logic last_q, last_d;

  always_ff @(posedge clk_pulse) begin
    if (clear) last_q <= 1'b1;
    else       last_q <= last_d;
  end

  always_comb begin
    valid  = req_0 | req_1;
    // Contention goes to whoever was not served last; a lone request wins outright.
    winner = (req_0 && req_1) ? ~last_q : req_1;
    last_d = (advance && valid) ? winner : last_q;
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Time-shares one external 11011 detector between two frame requesters.
// Each granted frame resets the detector, is shifted in MSB-first, and the
// detector hits seen during that frame are counted (saturating).
//   clk_pulse, clear      : clock, synchronous active-high reset
//   req_0/1, frame_0/1    : requests and their parallel frames
//   grant_0/1             : one-cycle accept pulses
//   det_clear/det_inp     : drive detector clear / serial input
//   det_out               : detector output
//   busy, done, done_id   : activity, completion pulse, finished requester
//   match_count           : hits in the last frame
module seq_detect_scheduler
  import seq_detect_scheduler_pkg::*;
#(
  parameter int FRAME_W = 16,
  parameter int CNT_W   = 4
) (
  input  logic               clk_pulse,
  input  logic               clear,
  input  logic               req_0,
  input  logic [FRAME_W-1:0] frame_0,
  input  logic               req_1,
  input  logic [FRAME_W-1:0] frame_1,
  output logic               grant_0,
  output logic               grant_1,
  output logic               det_clear,
  output logic               det_inp,
  input  logic               det_out,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic [CNT_W-1:0]   match_count
);

  localparam int BC_W = $clog2(FRAME_W) + 1;
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state_q, state_d;
  logic               id_q, id_d;           // requester owning the current frame
  logic               done_id_q, done_id_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;

  logic arb_adv, arb_winner, arb_valid;

  seq_rr_arbiter u_arb (
    .clk_pulse (clk_pulse),
    .clear     (clear),
    .req_0     (req_0),
    .req_1     (req_1),
    .advance   (arb_adv),
    .winner    (arb_winner),
    .valid     (arb_valid)
  );

  always_ff @(posedge clk_pulse) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      id_q      <= 1'b0;
      done_id_q <= 1'b0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      done_id_q <= done_id_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    done_id_d = done_id_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    arb_adv   = 1'b0;
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arb_valid) begin
          state_d = ST_GRANT;
          id_d    = arb_winner;
          arb_adv = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        sr_d      = id_q ? frame_1 : frame_0;
        cnt_d     = '0;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        sr_d = {sr_q[FRAME_W-2:0], 1'b0};
        // det_out lags det_inp by one cycle, so bit 0 of the window is the
        // post-clear detector state and is skipped.
        if (bit_cnt_q != '0 && det_out) cnt_d = cnt_inc;
        if (bit_cnt_q == LAST_BIT) state_d   = ST_DRAIN;
        else                       bit_cnt_d = bit_cnt_q + BC_W'(1);
      end
      ST_DRAIN: begin
        // Result of the final frame bit arrives here.
        if (det_out) cnt_d = cnt_inc;
        done_id_d = id_q;
        state_d   = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_0     = (state_q == ST_GRANT) && !id_q;
  assign grant_1     = (state_q == ST_GRANT) &&  id_q;
  assign det_clear   = clear || (state_q == ST_GRANT);
  assign det_inp     = (state_q == ST_SHIFT) && sr_q[FRAME_W-1];
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign done_id     = done_id_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
module tb_seq_detect_scheduler;

  logic        clk_pulse = 1'b0;
  logic        clear;
  logic        req_0, req_1;
  logic [15:0] frame_0, frame_1;
  logic        grant_0, grant_1, det_clear, det_inp, det_out, busy, done, done_id;
  logic [3:0]  match_count;

  logic        s_req_0, s_req_1;
  logic [15:0] s_frame_0, s_frame_1;
  logic        s_grant_0, s_grant_1, s_det_clear, s_det_inp, s_det_out, s_busy, s_done, s_done_id;
  logic [0:0]  s_match_count;

  int total = 0;
  int bad   = 0;

  always #5 clk_pulse = ~clk_pulse;

  seq_detect_scheduler #(.FRAME_W(16), .CNT_W(4)) dut (
    .clk_pulse(clk_pulse), .clear(clear),
    .req_0(req_0), .frame_0(frame_0), .req_1(req_1), .frame_1(frame_1),
    .grant_0(grant_0), .grant_1(grant_1), .det_clear(det_clear), .det_inp(det_inp),
    .det_out(det_out), .busy(busy), .done(done), .done_id(done_id),
    .match_count(match_count)
  );
  fsm_11011_moore det (.clk_pulse(clk_pulse), .clear(det_clear), .inp_1(det_inp), .out(det_out));

  seq_detect_scheduler #(.FRAME_W(16), .CNT_W(1)) dut_sat (
    .clk_pulse(clk_pulse), .clear(clear),
    .req_0(s_req_0), .frame_0(s_frame_0), .req_1(s_req_1), .frame_1(s_frame_1),
    .grant_0(s_grant_0), .grant_1(s_grant_1), .det_clear(s_det_clear), .det_inp(s_det_inp),
    .det_out(s_det_out), .busy(s_busy), .done(s_done), .done_id(s_done_id),
    .match_count(s_match_count)
  );
  fsm_11011_moore det_sat (.clk_pulse(clk_pulse), .clear(s_det_clear), .inp_1(s_det_inp), .out(s_det_out));

  typedef struct {
    int          w;
    logic [15:0] f;
    int          cnt;
  } vec_t;
  vec_t vecs[7];

  int gid[4], gcyc[4], dcnt[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Drives the request at the current negedge and follows the frame to completion.
  task automatic run_frame(input int w, input logic [15:0] f, input int exp_cnt,
                           input string nm);
    int n;
    logic g;
    logic [15:0] ser;
    if (w == 0) begin req_0 = 1'b1; frame_0 = f; end
    else        begin req_1 = 1'b1; frame_1 = f; end
    n = 0; g = 1'b0;
    while (!g && n < 40) begin
      @(negedge clk_pulse);
      n++;
      g = (w == 0) ? grant_0 : grant_1;
    end
    chk({nm, " grant_latency"}, n, 1);
    chk({nm, " other_grant"}, (w == 0) ? grant_1 : grant_0, 0);
    chk({nm, " det_clear_in_grant"}, det_clear, 1);
    if (w == 0) req_0 = 1'b0; else req_1 = 1'b0;
    ser = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_pulse);
      ser[15-k] = det_inp;
    end
    chk({nm, " serial"}, ser, f);
    @(negedge clk_pulse);
    chk({nm, " drain_busy_done"}, {busy, done, det_inp}, 3'b100);
    @(negedge clk_pulse);
    chk({nm, " done"}, done, 1);
    chk({nm, " done_id"}, done_id, w);
    chk({nm, " match_count"}, match_count, exp_cnt);
    @(negedge clk_pulse);
    chk({nm, " idle_after"}, {busy, done}, 2'b00);
    chk({nm, " count_hold"}, match_count, exp_cnt);
  endtask

  initial begin
    int n, ng, nd, cyc, g1cnt;
    logic both, seen;

    vecs[0] = '{0, 16'hD800, 1};
    vecs[1] = '{1, 16'hD9B0, 2};
    vecs[2] = '{0, 16'h0000, 0};
    vecs[3] = '{1, 16'hD800, 1};
    vecs[4] = '{0, 16'hD9B0, 2};
    vecs[5] = '{0, 16'h001B, 1};   // hit on the very last bit
    vecs[6] = '{1, 16'hFFFF, 0};

    clear = 1'b1; req_0 = 1'b0; req_1 = 1'b0; frame_0 = '0; frame_1 = '0;
    s_req_0 = 1'b0; s_req_1 = 1'b0; s_frame_0 = '0; s_frame_1 = '0;

    // Reset with a pending request: nothing may be granted.
    @(negedge clk_pulse);
    req_0 = 1'b1; frame_0 = 16'hD800;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_pulse);
      chk("reset outputs", {grant_0, grant_1, det_inp, busy, done, done_id}, 6'b0);
      chk("reset match_count", match_count, 0);
      chk("reset det_clear", det_clear, 1);
    end
    clear = 1'b0;
    run_frame(0, 16'hD800, 1, "rst_release");

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].w, vecs[i].f, vecs[i].cnt, $sformatf("vec%0d", i));

    // Contention: both requesters held; pointer reset so 0 goes first.
    clear = 1'b1;
    @(negedge clk_pulse);
    clear = 1'b0;
    req_0 = 1'b1; req_1 = 1'b1; frame_0 = 16'hD800; frame_1 = 16'hD9B0;
    for (int i = 0; i < 4; i++) begin gid[i] = -1; gcyc[i] = -1; dcnt[i] = -1; end
    ng = 0; nd = 0; cyc = 0; both = 1'b0;
    while (nd < 4 && cyc < 120) begin
      @(negedge clk_pulse);
      cyc++;
      if (grant_0 && grant_1) both = 1'b1;
      if (grant_0 || grant_1) begin
        if (ng < 4) begin gid[ng] = int'(grant_1); gcyc[ng] = cyc; end
        ng++;
        if (ng == 4) begin req_0 = 1'b0; req_1 = 1'b0; end
      end
      if (done) begin
        if (nd < 4) dcnt[nd] = int'(match_count);
        nd++;
      end
    end
    chk("contend done_count", nd, 4);
    chk("contend grant_count", ng, 4);
    chk("contend both_grants", both, 0);
    chk("contend first_latency", gcyc[0], 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("contend grant_id%0d", i), gid[i], i % 2);
      chk($sformatf("contend count%0d", i), dcnt[i], (i % 2) ? 2 : 1);
    end
    for (int i = 1; i < 4; i++)
      chk($sformatf("contend period%0d", i), gcyc[i] - gcyc[i-1], 19);
    @(negedge clk_pulse);

    // Abort at SHIFT k=6 after one hit is already counted.
    req_0 = 1'b1; frame_0 = 16'hD9B0;
    n = 0;
    while (!grant_0 && n < 10) begin @(negedge clk_pulse); n++; end
    chk("abort grant", grant_0, 1);
    req_0 = 1'b0;
    repeat (7) @(negedge clk_pulse);
    chk("abort k6 det_inp", det_inp, 0);
    chk("abort partial count", match_count, 1);
    clear = 1'b1;
    @(negedge clk_pulse);
    chk("abort outputs", {grant_0, grant_1, det_inp, busy, done}, 5'b0);
    chk("abort match_count", match_count, 0);
    chk("abort det_clear", det_clear, 1);
    clear = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk_pulse);
      if (done || busy) seen = 1'b1;
    end
    chk("abort no_done", seen, 0);
    run_frame(1, 16'hD9B0, 2, "post_abort");

    // Saturating counter and a withdrawn request on the CNT_W=1 instance.
    s_req_0 = 1'b1; s_frame_0 = 16'hD9B0;
    n = 0;
    while (!s_grant_0 && n < 10) begin @(negedge clk_pulse); n++; end
    chk("sat grant", s_grant_0, 1);
    s_req_0 = 1'b0;
    @(negedge clk_pulse);
    s_req_1 = 1'b1; s_frame_1 = 16'hFFFF;
    @(negedge clk_pulse);
    s_req_1 = 1'b0;
    n = 0; g1cnt = 0;
    while (!s_done && n < 30) begin
      @(negedge clk_pulse);
      n++;
      if (s_grant_1) g1cnt++;
    end
    chk("sat done", s_done, 1);
    chk("sat match_count", s_match_count, 1);
    chk("sat done_id", s_done_id, 0);
    repeat (5) begin
      @(negedge clk_pulse);
      if (s_grant_1) g1cnt++;
    end
    chk("withdrawn no_grant", g1cnt, 0);
    chk("withdrawn idle", s_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
